// File: rtl/systolic_ws_array.sv
// Weight-stationary ROWS x COLS MAC array: y[c] = sum_r x[r]*w[r][c].
// Features are skewed in, partial sums flow down, and results are de-skewed so callers see aligned vectors.
module systolic_ws_array #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int ROWS   = 4,
  parameter int COLS   = 4
) (
  input  logic                    clk_in,
  input  logic                    nrst_in,
  input  logic                    cmd_load,
  input  logic                    cmd_run,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [COLS*DATA_W-1:0]  w_row,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [ROWS*DATA_W-1:0]  in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_vec,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state_o
);

  // Every handshake transfers on a rising edge where valid & ready are both high;
  // a valid beat holds its payload until then, and ready never depends on the same side's valid.
  localparam int L  = ROWS + COLS;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              row_cnt_q, row_cnt_d;
  logic                       done_q, done_d;
  logic                       adv, accept_x;
  logic [L-1:0]               valid_q;
  logic signed [DATA_W-1:0]   w_q   [ROWS][COLS];
  logic signed [DATA_W-1:0]   x_in  [ROWS];
  logic signed [DATA_W-1:0]   x_sk  [ROWS];
  logic signed [DATA_W-1:0]   x_pe  [ROWS][COLS];
  logic signed [DATA_W-1:0]   x_q   [ROWS][COLS];
  logic signed [2*DATA_W-1:0] prod  [ROWS][COLS];
  logic signed [ACC_W-1:0]    ps_d  [ROWS][COLS];
  logic signed [ACC_W-1:0]    ps_q  [ROWS][COLS];
  logic signed [ACC_W-1:0]    y_dsk [COLS];
  logic [COLS*ACC_W-1:0]      out_vec_q;

  assign out_valid   = valid_q[L-1];
  assign adv         = out_ready | ~out_valid;
  assign accept_x    = in_valid & in_ready;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign out_vec     = out_vec_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    w_ready   = 1'b0;
    in_ready  = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_load) begin
          state_d   = S_LOAD;
          row_cnt_d = '0;
        end else if (cmd_run) begin
          state_d = S_COMPUTE;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          if (row_cnt_q == CW'(ROWS - 1)) begin
            state_d   = S_IDLE;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + CW'(1);
          end
        end
      end
      S_COMPUTE: begin
        in_ready = adv;
        if (in_valid && adv && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (~|valid_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      done_q    <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      done_q    <= done_d;
      if (adv) valid_q <= {valid_q[L-2:0], accept_x};
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
    end else if (w_ready && w_valid) begin
      for (int r = 0; r < ROWS; r++)
        if (row_cnt_q == CW'(r))
          for (int c = 0; c < COLS; c++) w_q[r][c] <= w_row[c*DATA_W +: DATA_W];
    end
  end

  // Non-accepted cycles inject zeros so bubbles carry deterministic data.
  always_comb begin
    for (int r = 0; r < ROWS; r++)
      x_in[r] = accept_x ? in_vec[r*DATA_W +: DATA_W] : '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_pass
      assign x_sk[0] = x_in[0];
    end else begin : g_dly
      logic signed [DATA_W-1:0] sr_q [r];
      always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
          for (int i = 0; i < r; i++) sr_q[i] <= '0;
        end else if (adv) begin
          sr_q[0] <= x_in[r];
          for (int i = 1; i < r; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign x_sk[r] = sr_q[r-1];
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      x_pe[r][0] = x_sk[r];
      for (int c = 1; c < COLS; c++) x_pe[r][c] = x_q[r][c-1];
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        prod[r][c] = (2*DATA_W)'(x_pe[r][c]) * (2*DATA_W)'(w_q[r][c]);
    for (int c = 0; c < COLS; c++) begin
      ps_d[0][c] = ACC_W'(prod[0][c]);
      for (int r = 1; r < ROWS; r++) ps_d[r][c] = ps_q[r-1][c] + ACC_W'(prod[r][c]);
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          x_q[r][c]  <= '0;
          ps_q[r][c] <= '0;
        end
    end else if (adv) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          x_q[r][c]  <= x_pe[r][c];
          ps_q[r][c] <= ps_d[r][c];
        end
    end
  end

  // Column c leaves the bottom row c cycles late; pad it so all columns line up.
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign y_dsk[c] = ps_q[ROWS-1][c];
    end else begin : g_dly
      logic signed [ACC_W-1:0] d_q [D];
      always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
          for (int i = 0; i < D; i++) d_q[i] <= '0;
        end else if (adv) begin
          d_q[0] <= ps_q[ROWS-1][c];
          for (int i = 1; i < D; i++) d_q[i] <= d_q[i-1];
        end
      end
      assign y_dsk[c] = d_q[D-1];
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      out_vec_q <= '0;
    end else if (adv) begin
      for (int c = 0; c < COLS; c++) out_vec_q[c*ACC_W +: ACC_W] <= y_dsk[c];
    end
  end

endmodule

// File: tb/tb_systolic_ws_array.sv
// Bench for systolic_ws_array: random passes checked against a plain matrix-vector model,
// with a second 16-bit-accumulator instance on the same stimulus to exercise wrap-around.
module tb_systolic_ws_array;

  localparam int DW   = 8;
  localparam int AW   = 20;
  localparam int AW16 = 16;
  localparam int R    = 4;
  localparam int C    = 4;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              nrst_in, cmd_load, cmd_run, w_valid, in_valid, in_last, out_ready;
  logic [C*DW-1:0]   w_row;
  logic [R*DW-1:0]   in_vec;
  logic              w_ready, in_ready, out_valid, busy, done;
  logic [C*AW-1:0]   out_vec;
  logic [1:0]        dbg_state;
  logic              w_ready16, in_ready16, out_valid16, busy16, done16;
  logic [C*AW16-1:0] out_vec16;
  logic [1:0]        dbg_state16;

  systolic_ws_array #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C)) dut (
    .clk_in(clk_in), .nrst_in(nrst_in), .cmd_load(cmd_load), .cmd_run(cmd_run),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  systolic_ws_array #(.DATA_W(DW), .ACC_W(AW16), .ROWS(R), .COLS(C)) dut16 (
    .clk_in(clk_in), .nrst_in(nrst_in), .cmd_load(cmd_load), .cmd_run(cmd_run),
    .w_valid(w_valid), .w_ready(w_ready16), .w_row(w_row),
    .in_valid(in_valid), .in_ready(in_ready16), .in_last(in_last), .in_vec(in_vec),
    .out_valid(out_valid16), .out_ready(out_ready), .out_vec(out_vec16),
    .busy(busy16), .done(done16), .dbg_state_o(dbg_state16)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wm [R][C];
  int wl [R][C];
  logic [C*AW-1:0]   exp_q[$];
  logic [C*AW16-1:0] exp16_q[$];
  logic [R*DW-1:0]   stim_q[$];
  int cyc = 0, first_acc = -1, first_out = -1, done_cnt = 0, n_out = 0, n_out16 = 0;
  int or_mode = 0;
  logic [C*AW-1:0]   last_out = '0;
  logic [C*AW16-1:0] last_out16 = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [R*DW-1:0] pk8(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [C*AW-1:0] pk20(input int a, input int b, input int c, input int d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  function automatic logic [R*DW-1:0] rand_vec();
    logic [R*DW-1:0] v;
    for (int r = 0; r < R; r++) v[r*DW +: DW] = DW'($urandom_range(0, 255));
    return v;
  endfunction

  // y[c] = sum_r x[r]*w[r][c] in full precision, then truncated to each instance's width.
  function automatic void model_push(input logic [R*DW-1:0] v);
    logic [C*AW-1:0]   e;
    logic [C*AW16-1:0] e16;
    longint y;
    for (int c = 0; c < C; c++) begin
      y = 0;
      for (int r = 0; r < R; r++) y += longint'($signed(v[r*DW +: DW])) * longint'(wm[r][c]);
      e[c*AW +: AW]       = y[AW-1:0];
      e16[c*AW16 +: AW16] = y[AW16-1:0];
    end
    exp_q.push_back(e);
    exp16_q.push_back(e16);
  endfunction

  always @(negedge clk_in) begin
    cyc++;
    if (nrst_in) begin
      if (in_valid && in_ready) begin
        model_push(in_vec);
        if (first_acc < 0) first_acc = cyc;
      end
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          chk("out_vec", out_vec, exp_q[0]);
          if (out_ready) begin
            last_out = out_vec;
            exp_q.delete(0);
            n_out++;
          end
        end
      end
      if (out_valid16) begin
        if (exp16_q.size() == 0) chk("spurious_out16", out_valid16, 1'b0);
        else begin
          chk("out_vec16", out_vec16, exp16_q[0]);
          if (out_ready) begin
            last_out16 = out_vec16;
            exp16_q.delete(0);
            n_out16++;
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_w(input logic [C*DW-1:0] row);
    bit ok;
    ok = 1'b0;
    w_valid = 1'b1;
    w_row   = row;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk_in);
      if (w_ready) ok = 1'b1;
    end
    tick();
    chk("w_handshake_timeout", ok, 1'b1);
    w_valid = 1'b0;
  endtask

  task automatic send_x(input logic [R*DW-1:0] v, input bit last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_vec   = v;
    in_last  = last;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk_in);
      if (in_ready) ok = 1'b1;
    end
    tick();
    chk("in_handshake_timeout", ok, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_weights(input bit both_cmds, input bit gaps);
    logic [C*DW-1:0] row;
    cmd_load = 1'b1;
    cmd_run  = both_cmds;
    tick();
    cmd_load = 1'b0;
    cmd_run  = 1'b0;
    chk("load_w_ready", w_ready, 1'b1);
    chk("load_in_ready", in_ready, 1'b0);
    for (int r = 0; r < R; r++) begin
      if (gaps) begin
        cmd_run = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        cmd_run = 1'b0;
        chk("load_ignores_run", w_ready, 1'b1);
      end
      for (int c = 0; c < C; c++) row[c*DW +: DW] = DW'(wl[r][c]);
      send_w(row);
      chk("load_busy_after_beat", busy, (r < R - 1) ? 1'b1 : 1'b0);
    end
    chk("load_end_w_ready", w_ready, 1'b0);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = wl[r][c];
  endtask

  task automatic run_pass(input int n, input int gap);
    bit ok;
    done_cnt = 0;
    n_out    = 0;
    n_out16  = 0;
    cmd_run  = 1'b1;
    tick();
    cmd_run  = 1'b0;
    chk("run_busy", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      send_x(stim_q.pop_front(), i == n - 1);
      if (i == n - 1) chk("drain_in_ready", in_ready, 1'b0);
      if (gap > 0) repeat (gap) tick();
      else if (gap < 0) repeat ($urandom_range(0, 2)) tick();
    end
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk_in);
      if (!busy) ok = 1'b1;
    end
    chk("drain_timeout", ok, 1'b1);
    repeat (2) @(negedge clk_in);
    tick();
    chk("done_once", done_cnt, 1);
    chk("result_count", n_out, n);
    chk("result_count16", n_out16, n);
    chk("nothing_lost", exp_q.size(), 0);
  endtask

  initial begin
    nrst_in  = 1'b0;
    cmd_load = 1'b0;
    cmd_run  = 1'b0;
    w_valid  = 1'b0;
    w_row    = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_vec   = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = 0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_vec", out_vec, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    tick();
    nrst_in = 1'b1;
    tick();

    // Identity weights: y must equal x, with fixed latency.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wl[r][c] = (r == c) ? 1 : 0;
    load_weights(1'b0, 1'b0);
    stim_q.push_back(pk8(1, 2, 3, 4));
    stim_q.push_back(pk8(-5, 6, -7, 8));
    first_acc = -1;
    first_out = -1;
    run_pass(2, 0);
    chk("t1_latency", first_out - first_acc, R + C);
    chk("t1_y", last_out, pk20(-5, 6, -7, 8));

    // Most negative operands: 4*16384 fits in 20 bits, wraps to 0 in 16.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wl[r][c] = -128;
    load_weights(1'b0, 1'b0);
    stim_q.push_back(pk8(-128, -128, -128, -128));
    run_pass(1, 0);
    chk("t2_y20", last_out, pk20(65536, 65536, 65536, 65536));
    chk("t2_y16_wrap", last_out16, '0);

    // Simultaneous commands, run pulses during load, gapped weight beats.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wl[r][c] = int'($urandom_range(0, 255)) - 128;
    load_weights(1'b1, 1'b1);

    or_mode = 1;
    for (int i = 0; i < 10; i++) stim_q.push_back(rand_vec());
    run_pass(10, 0);
    or_mode = 0;

    // Weights persist; bubble pattern 1,0,0,1.
    for (int i = 0; i < 2; i++) stim_q.push_back(rand_vec());
    run_pass(2, 2);

    or_mode = 2;
    for (int i = 0; i < 12; i++) stim_q.push_back(rand_vec());
    run_pass(12, -1);
    or_mode = 0;

    // Reset in the middle of a pass.
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int i = 0; i < 3; i++) send_x(rand_vec(), 1'b0);
    tick();
    #2;
    nrst_in = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_vec", out_vec, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    exp_q.delete();
    exp16_q.delete();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = 0;
    done_cnt = 0;
    repeat (2) tick();
    nrst_in = 1'b1;
    repeat (3) tick();
    chk("mid_rst_no_done", done_cnt, 0);
    stim_q.push_back(pk8(1, 1, 1, 1));
    run_pass(1, 0);
    chk("t5_zero_weights", last_out, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
